// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART byte receiver: FSM state encoding and
// default bit timing derived from the system clock and baud rate.
package uart_rx_pkg;

  localparam int SYS_CLK_HZ       = 50_250_000;
  localparam int BAUD             = 115_200;
  // 50.25 MHz / 115200 = 436.2; the truncated value gives 0.05 % error.
  localparam int DEF_CLKS_PER_BIT = SYS_CLK_HZ / BAUD;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Byte delivery interface between the UART receiver (master) and the
// downstream command logic (slave). Valid/ready handshake plus status pulses.
interface uart_rx_if;
  import uart_rx_pkg::*;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_frame_err;
  logic       rx_overrun;
  logic       rx_busy;

  modport master (
    output rx_data,
    output rx_valid,
    output rx_frame_err,
    output rx_overrun,
    output rx_busy,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  rx_frame_err,
    input  rx_overrun,
    input  rx_busy,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input. The reset
// value is a parameter so idle-high lines do not see a false edge at reset.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops to resolve metastability on the raw pin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART byte receiver. Synchronises the serial line, qualifies the start
// bit at mid-bit, samples eight data bits LSB first and hands each byte to
// the consumer on a valid/ready interface. Frame errors and overruns are
// reported as single-cycle pulses.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic     CLK,
  input  logic     RESET,
  input  logic     UART_RX,
  uart_rx_if.master rx
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] LAST_HALF = CNT_W'(HALF_BIT - 1);

  logic             rxs;
  logic             rxs_d;
  logic             fall;

  rx_state_t        state_q, state_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             stop_ok;
  logic             stop_bad;

  logic [7:0]       data_q;
  logic             valid_q;
  logic             frame_err_q;
  logic             overrun_q;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk (CLK),
    .rst (RESET),
    .d   (UART_RX),
    .q   (rxs)
  );

  // Delayed copy of the synchronised line for falling-edge detection.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) rxs_d <= 1'b1;
    else       rxs_d <= rxs;
  end

  assign fall = rxs_d & ~rxs;

  // FSM state, bit/clock counters and the data shift register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
    end
  end

  // Next-state logic: counter wraps to zero at every sample point.
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q + CNT_W'(1);
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    stop_ok   = 1'b0;
    stop_bad  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        clk_cnt_d = '0;
        if (fall) begin
          state_d   = ST_START;
          bit_cnt_d = '0;
        end
      end
      ST_START: begin
        if (clk_cnt_q == LAST_HALF) begin
          clk_cnt_d = '0;
          // A line back high at mid start bit is a glitch, not a frame.
          state_d   = rxs ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (clk_cnt_q == LAST_BIT) begin
          clk_cnt_d = '0;
          shift_d   = {rxs, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (clk_cnt_q == LAST_BIT) begin
          clk_cnt_d = '0;
          state_d   = ST_IDLE;
          stop_ok   = rxs;
          stop_bad  = ~rxs;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        clk_cnt_d = '0;
      end
    endcase
  end

  // Output holding register with valid/ready handshake and status pulses.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= stop_bad;
      overrun_q   <= 1'b0;
      if (stop_ok) begin
        // A byte accepted in the same cycle frees the slot for the new one.
        if (!valid_q || rx.rx_ready) begin
          data_q  <= shift_q;
          valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (valid_q && rx.rx_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign rx.rx_data      = data_q;
  assign rx.rx_valid     = valid_q;
  assign rx.rx_frame_err = frame_err_q;
  assign rx.rx_overrun   = overrun_q;
  assign rx.rx_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: table of frames plus hand sequences for latency,
// overrun, glitch, break and mid-frame reset. Bytes expected at the
// consumer are queued when sent and popped on each handshake.
module tb_uart_rx;
  import uart_rx_pkg::*;

  localparam int CPB  = 436;
  localparam int HALF = CPB / 2;
  // Pin fall to rx_valid: 2 sync + 1 edge, then half bit and nine bits.
  localparam int LAT  = 3 + HALF + 9 * CPB;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic line = 1'b1;

  uart_rx_if u_if();

  uart_rx #(.CLKS_PER_BIT(CPB), .HALF_BIT(HALF)) dut (
    .CLK     (clk),
    .RESET   (rst),
    .UART_RX (line),
    .rx      (u_if)
  );

  always #10 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ferr_cnt = 0, ovr_cnt = 0, hi_cnt = 0;
  int rise_cyc = 0, fall_cyc = 0;
  logic prev_valid = 1'b0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_ferr;
  } vec_t;
  vec_t tbl[4];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Scoreboard and pulse monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (u_if.rx_valid && u_if.rx_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got %0h required none", u_if.rx_data);
      end else begin
        check("sb_data", {24'h0, u_if.rx_data}, {24'h0, exp_q.pop_front()});
      end
    end
    if (u_if.rx_frame_err) ferr_cnt++;
    if (u_if.rx_overrun)   ovr_cnt++;
    if (u_if.rx_valid)     hi_cnt++;
    if (u_if.rx_valid && !prev_valid) rise_cyc = cyc;
    prev_valid = u_if.rx_valid;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives start, 8 data bits LSB first and the stop bit; leaves line at stop level.
  task automatic send(input logic [7:0] b, input logic stop);
    @(posedge clk); #1;
    fall_cyc = cyc;
    line = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 8; i++) begin
      line = b[i];
      wait_clks(CPB);
    end
    line = stop;
    wait_clks(CPB);
  endtask

  initial begin
    int ferr0, ovr0, hi0;
    tbl[0] = '{8'h00, 1'b1, 0};
    tbl[1] = '{8'h5A, 1'b1, 0};
    tbl[2] = '{8'h81, 1'b0, 1};
    tbl[3] = '{8'h7E, 1'b1, 0};

    u_if.rx_ready = 1'b1;
    wait_clks(5);
    rst = 1'b0;
    wait_clks(2000);
    check("rst_data",  {24'h0, u_if.rx_data}, 32'h0);
    check("rst_valid", {31'h0, u_if.rx_valid}, 32'h0);
    check("rst_ferr",  {31'h0, u_if.rx_frame_err}, 32'h0);
    check("rst_ovr",   {31'h0, u_if.rx_overrun}, 32'h0);
    check("rst_busy",  {31'h0, u_if.rx_busy}, 32'h0);

    // 0xA5 with consumer ready: one-cycle valid at the exact latency.
    hi0 = hi_cnt;
    exp_q.push_back(8'hA5);
    send(8'hA5, 1'b1);
    line = 1'b1;
    wait_clks(CPB);
    check("a5_latency", rise_cyc - fall_cyc, LAT);
    check("a5_valid_cycles", hi_cnt - hi0, 1);
    check("a5_delivered", exp_q.size(), 0);

    // Table of frames, some with a bad stop bit.
    for (int i = 0; i < 4; i++) begin
      ferr0 = ferr_cnt;
      hi0   = hi_cnt;
      if (tbl[i].stop) exp_q.push_back(tbl[i].data);
      send(tbl[i].data, tbl[i].stop);
      line = 1'b1;
      wait_clks(2 * CPB);
      check("tbl_ferr", ferr_cnt - ferr0, tbl[i].exp_ferr);
      check("tbl_valid_cycles", hi_cnt - hi0, tbl[i].stop ? 1 : 0);
      check("tbl_busy", {31'h0, u_if.rx_busy}, 32'h0);
    end
    check("tbl_delivered", exp_q.size(), 0);

    // Back-to-back frames with consumer stalled: second byte overruns.
    u_if.rx_ready = 1'b0;
    ovr0  = ovr_cnt;
    ferr0 = ferr_cnt;
    exp_q.push_back(8'h3C);
    send(8'h3C, 1'b1);
    line = 1'b1;
    send(8'hC3, 1'b1);
    line = 1'b1;
    wait_clks(CPB);
    check("ovr_pulses", ovr_cnt - ovr0, 1);
    check("ovr_valid", {31'h0, u_if.rx_valid}, 32'h1);
    check("ovr_data", {24'h0, u_if.rx_data}, 32'h3C);
    check("ovr_ferr", ferr_cnt - ferr0, 0);
    u_if.rx_ready = 1'b1;
    wait_clks(1);
    check("ovr_valid_drop", {31'h0, u_if.rx_valid}, 32'h0);
    check("ovr_delivered", exp_q.size(), 0);

    // 100-clock glitch on the idle line.
    ferr0 = ferr_cnt; ovr0 = ovr_cnt; hi0 = hi_cnt;
    @(posedge clk); #1;
    line = 1'b0;
    wait_clks(100);
    line = 1'b1;
    check("glitch_busy", {31'h0, u_if.rx_busy}, 32'h1);
    wait_clks(HALF);
    check("glitch_idle", {31'h0, u_if.rx_busy}, 32'h0);
    check("glitch_valid", hi_cnt - hi0, 0);
    check("glitch_flags", (ferr_cnt - ferr0) + (ovr_cnt - ovr0), 0);

    // Break: bad stop bit then line held low for 20 bit times.
    ferr0 = ferr_cnt; hi0 = hi_cnt;
    send(8'h55, 1'b0);
    wait_clks(20 * CPB);
    check("brk_ferr", ferr_cnt - ferr0, 1);
    check("brk_valid", hi_cnt - hi0, 0);
    check("brk_busy", {31'h0, u_if.rx_busy}, 32'h0);
    line = 1'b1;
    wait_clks(CPB);
    exp_q.push_back(8'h01);
    send(8'h01, 1'b1);
    line = 1'b1;
    wait_clks(2 * CPB);
    check("brk_recover", exp_q.size(), 0);
    check("brk_ferr_once", ferr_cnt - ferr0, 1);

    // Reset during data bit 4 with a stalled byte pending.
    u_if.rx_ready = 1'b0;
    send(8'h96, 1'b1);
    line = 1'b1;
    wait_clks(CPB);
    @(posedge clk); #1;
    line = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 4; i++) begin
      line = i[0];
      wait_clks(CPB);
    end
    line = 1'b0;
    wait_clks(CPB / 2);
    check("mid_busy", {31'h0, u_if.rx_busy}, 32'h1);
    check("mid_valid", {31'h0, u_if.rx_valid}, 32'h1);
    rst  = 1'b1;
    line = 1'b1;
    #1;
    check("mid_rst_valid", {31'h0, u_if.rx_valid}, 32'h0);
    check("mid_rst_data",  {24'h0, u_if.rx_data}, 32'h0);
    check("mid_rst_busy",  {31'h0, u_if.rx_busy}, 32'h0);
    check("mid_rst_flags", {30'h0, u_if.rx_frame_err, u_if.rx_overrun}, 32'h0);
    wait_clks(CPB);
    rst = 1'b0;
    u_if.rx_ready = 1'b1;
    wait_clks(CPB);
    exp_q.push_back(8'hFF);
    send(8'hFF, 1'b1);
    line = 1'b1;
    wait_clks(2 * CPB);
    check("post_rst_rx", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
